// File: rtl/backward_layer_seq.sv
// Backward-pass sequencer: walks the backward layers in fixed order for every
// sample of a batch, issuing one launch pulse per layer and watching for timeouts.
`ifndef BATCH_SIZE
`define BATCH_SIZE 2
`endif
`ifndef STATE_LEN
`define STATE_LEN 4
`endif

module backward_layer_seq #(
  parameter int BATCH_SIZE = `BATCH_SIZE,
  parameter int TIMEOUT    = 1024,
  localparam int BW        = (BATCH_SIZE > 1) ? $clog2(BATCH_SIZE) : 1,
  localparam int CW        = $clog2(TIMEOUT + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  layer_valid,
  output logic [`STATE_LEN-1:0] state,
  output logic                  run,
  output logic [BW-1:0]         batch_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [`STATE_LEN-1:0] {
    B_IDLE, B_DENS, B_TANH3, B_MIX3, B_TANH2, B_MIX2, B_TANH1, B_MIX1, B_EMB
  } state_t;

  state_t          cur_state, next_state;
  logic            run_q, next_run;
  logic            busy_q;
  logic            done_q, next_done;
  logic            err_q, next_err;
  logic [BW-1:0]   batch_q, next_batch;
  logic [CW-1:0]   cnt_q, next_cnt;
  logic            lv_hold;
  logic            wait_cycle;
  logic            valid_ok;

  function automatic state_t next_layer(input state_t s);
    case (s)
      B_DENS:  return B_TANH3;
      B_TANH3: return B_MIX3;
      B_MIX3:  return B_TANH2;
      B_TANH2: return B_MIX2;
      B_MIX2:  return B_TANH1;
      B_TANH1: return B_MIX1;
      B_MIX1:  return B_EMB;
      default: return B_IDLE;
    endcase
  endfunction

  // A completion counts only once per high phase of layer_valid, and never in the run cycle.
  assign wait_cycle = (cur_state != B_IDLE) && !run_q;
  assign valid_ok   = wait_cycle && layer_valid && !lv_hold;

  always_comb begin
    next_state = cur_state;
    next_run   = 1'b0;
    next_done  = 1'b0;
    next_err   = err_q;
    next_batch = batch_q;
    next_cnt   = '0;
    if (cur_state == B_IDLE) begin
      if (start && !done_q) begin
        next_state = B_DENS;
        next_run   = 1'b1;
        next_batch = '0;
        next_err   = 1'b0;
      end
    end else if (abort) begin
      next_state = B_IDLE;
    end else if (valid_ok) begin
      if (cur_state == B_EMB) begin
        if (batch_q == BW'(BATCH_SIZE - 1)) begin
          next_state = B_IDLE;
          next_done  = 1'b1;
        end else begin
          next_state = B_DENS;
          next_run   = 1'b1;
          next_batch = batch_q + 1'b1;
        end
      end else begin
        next_state = next_layer(cur_state);
        next_run   = 1'b1;
      end
    end else if (wait_cycle && cnt_q == CW'(TIMEOUT - 1)) begin
      next_state = B_IDLE;
      next_err   = 1'b1;
    end else begin
      next_cnt = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= B_IDLE;
      run_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      batch_q   <= '0;
      cnt_q     <= '0;
    end else begin
      cur_state <= next_state;
      run_q     <= next_run;
      busy_q    <= (next_state != B_IDLE);
      done_q    <= next_done;
      err_q     <= next_err;
      batch_q   <= next_batch;
      cnt_q     <= next_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lv_hold <= 1'b0;
    else if (!layer_valid)
      lv_hold <= 1'b0;
    else if (valid_ok)
      lv_hold <= 1'b1;
  end

  assign state     = cur_state;
  assign run       = run_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign batch_idx = batch_q;

endmodule

// File: tb/tb_backward_layer_seq.sv
// Scoreboard bench for backward_layer_seq: expected run/done events are queued
// by the stimulus and popped by a monitor whenever the DUT pulses run or done.
module tb_backward_layer_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       layer_valid = 1'b0;
  logic [3:0] state;
  logic       run;
  logic [0:0] batch_idx;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int st;
    int b;
    bit dn;
  } exp_t;

  exp_t exp_q[$];

  backward_layer_seq #(.BATCH_SIZE(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .layer_valid(layer_valid), .state(state), .run(run),
    .batch_idx(batch_idx), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic push_run(input int st, input int b);
    exp_q.push_back('{st: st, b: b, dn: 1'b0});
  endtask

  task automatic push_pass(input int batches);
    for (int b = 0; b < batches; b++)
      for (int s = 1; s <= 8; s++) push_run(s, b);
    exp_q.push_back('{st: 0, b: batches - 1, dn: 1'b1});
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // From a run cycle, raise layer_valid three cycles later for one cycle.
  task automatic finish_layer();
    repeat (3) @(posedge clk);
    #1 layer_valid = 1'b1;
    @(posedge clk); #1 layer_valid = 1'b0;
  endtask

  task automatic do_abort();
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check_output("abort_idle", busy, 0);
  endtask

  task automatic check_idle(input string name);
    check_output({name, "_state"}, state, 0);
    check_output({name, "_run"}, run, 0);
    check_output({name, "_busy"}, busy, 0);
    check_output({name, "_done"}, done, 0);
  endtask

  // Monitor: every run or done pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n && (run || done)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_event: run=%0d done=%0d state=%0d, expected no event", run, done, state);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_output("ev_state", state, e.st);
        check_output("ev_batch", batch_idx, e.b);
        check_output("ev_done", done, e.dn);
        check_output("ev_busy", busy, e.dn ? 0 : 1);
        check_output("ev_err", err, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not end, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    #12;
    check_idle("reset");
    check_output("reset_err", err, 0);
    check_output("reset_batch", batch_idx, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_idle("post_reset");

    // Full pass of two samples; start asserted with the final completion is ignored
    push_pass(2);
    do_start();
    repeat (15) finish_layer();
    repeat (3) @(posedge clk);
    #1 layer_valid = 1'b1; start = 1'b1;
    @(posedge clk); #1 layer_valid = 1'b0; start = 1'b0;
    check_output("pass_done", done, 1);
    check_output("pass_busy", busy, 0);
    check_output("pass_batch_hold", batch_idx, 1);
    @(posedge clk); #1
    check_output("done_single", done, 0);
    check_output("pass_queue_empty", exp_q.size(), 0);

    // Timeout: no layer_valid after the B_DENS run
    push_run(1, 0);
    do_start();
    repeat (15) @(posedge clk);
    #1 check_output("to_still_busy", busy, 1);
    check_output("to_err_early", err, 0);
    @(posedge clk); #1
    check_output("to_err", err, 1);
    check_idle("to");
    repeat (3) @(posedge clk);
    #1 check_output("to_err_sticky", err, 1);
    push_run(1, 0);
    do_start();
    check_output("to_err_cleared", err, 0);

    // Abort coinciding with layer_valid in B_TANH2
    push_run(2, 0); finish_layer();
    push_run(3, 0); finish_layer();
    push_run(4, 0); finish_layer();
    repeat (2) @(posedge clk);
    #1 abort = 1'b1; layer_valid = 1'b1;
    @(posedge clk); #1 abort = 1'b0; layer_valid = 1'b0;
    check_idle("abort");
    check_output("abort_err", err, 0);
    repeat (3) @(posedge clk);
    #1 check_idle("abort_later");

    // Hazards: start while busy, layer_valid held five cycles in B_MIX3
    push_run(1, 0);
    do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 layer_valid = 1'b1;
    push_run(2, 0);
    @(posedge clk); #1 layer_valid = 1'b0;
    push_run(3, 0); finish_layer();
    push_run(4, 0);
    repeat (3) @(posedge clk);
    #1 layer_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1 layer_valid = 1'b0;
    check_output("hold_one_advance", state, 4);
    push_run(5, 0);
    @(posedge clk); #1 layer_valid = 1'b1;
    @(posedge clk); #1 layer_valid = 1'b0;
    check_output("hold_next_layer", state, 5);
    do_abort();

    // Mid-pass reset during B_MIX1 of sample 1
    for (int b = 0; b < 2; b++)
      for (int s = 1; s <= 8; s++)
        if (!(b == 1 && s == 8)) push_run(s, b);
    do_start();
    repeat (14) finish_layer();
    check_output("pre_reset_state", state, 7);
    check_output("pre_reset_batch", batch_idx, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1 check_idle("mid_reset");
    check_output("mid_reset_err", err, 0);
    check_output("mid_reset_batch", batch_idx, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_idle("after_reset");
    push_run(1, 0);
    do_start();
    check_output("restart_batch", batch_idx, 0);
    do_abort();

    repeat (2) @(posedge clk);
    #1 check_output("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
